// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver: OFF / INSTANT / STRETCH / BLINK per channel, shared blink phase.
// Optional per-channel rising-edge event counters are enabled by defining STATUS_LED_EVENT_COUNT_EN.
module status_led_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int CNT_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       EVENT,
  input  logic [2*NUM_CH-1:0]     MODE,
  input  logic                    CLEAR,
  output logic [NUM_CH-1:0]       LED,
  output logic [NUM_CH-1:0]       ACTIVE,
  output logic [NUM_CH*CNT_W-1:0] EVT_COUNT
);

  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
  localparam int DIV_W = $clog2(BLINK_DIV + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_INSTANT = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             w_phase_next;

  assign w_phase_next = (r_div == DIV_LAST) ? ~r_phase : r_phase;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_div   <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_phase <= w_phase_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      mode_e            w_mode;
      logic [TMR_W-1:0] r_timer;
      logic [TMR_W-1:0] w_timer_next;
      logic             w_active_next;
      logic             w_led_next;
      logic             r_led;
      logic             r_active;

      assign w_mode = mode_e'(MODE[2*gi +: 2]);

      // BLINK uses the next-cycle phase so the registered LED lines up with the phase register.
      always_comb begin
        w_timer_next  = '0;
        w_active_next = 1'b0;
        w_led_next    = 1'b0;
        case (w_mode)
          MODE_INSTANT: w_led_next = EVENT[gi];
          MODE_STRETCH, MODE_BLINK: begin
            if (EVENT[gi]) begin
              w_timer_next  = HOLD_LOAD;
              w_active_next = 1'b1;
            end else if (r_timer != '0) begin
              w_timer_next  = r_timer - 1'b1;
              w_active_next = 1'b1;
            end
            w_led_next = (w_mode == MODE_BLINK) ? (w_active_next & w_phase_next)
                                                : w_active_next;
          end
          default: ;
        endcase
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_timer  <= '0;
          r_led    <= 1'b0;
          r_active <= 1'b0;
        end else begin
          r_timer  <= w_timer_next;
          r_led    <= w_led_next;
          r_active <= w_active_next;
        end
      end

      assign LED[gi]    = r_led;
      assign ACTIVE[gi] = r_active;
    end
  endgenerate

`ifdef STATUS_LED_EVENT_COUNT_EN
  logic [NUM_CH-1:0] r_event_prev;

  always_ff @(posedge CLK) begin
    if (RESET) r_event_prev <= '0;
    else       r_event_prev <= EVENT;
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // CLEAR wins over a coincident rising edge; the count saturates instead of wrapping.
      always_ff @(posedge CLK) begin
        if (RESET || CLEAR) begin
          r_cnt <= '0;
        end else if (EVENT[gi] && !r_event_prev[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign EVT_COUNT[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`else
  logic w_unused_clear;
  assign w_unused_clear = CLEAR;
  assign EVT_COUNT      = '0;
`endif

endmodule
